// File: rtl/safety_fault_responder.sv
// rtl/safety_fault_responder.sv - per-axis amplifier enable sequencer with fault latch and DAC ramp-down
// Optional controlled ramp to zero current on fault: define SAFETY_RAMP_EN.
module safety_fault_responder #(
    parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
    parameter logic [15:0] RAMP_STEP     = 16'h0100,
    parameter logic [15:0] RAMP_DIV      = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fault_in,
    input  logic [15:0] dac_cmd_in,
    input  logic        enable_req,
    input  logic        clear_req,
    output logic [15:0] dac_out,
    output logic        amp_enable,
    output logic        fault_latched,
    output logic [2:0]  state_out,
    output logic [7:0]  fault_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        RUN    = 3'd2,
        RAMP   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [15:0] DAC_ZERO = 16'h8000;

    state_t      state, state_nxt;
    logic [15:0] dac_nxt;
    logic [15:0] settle_cnt, settle_cnt_nxt;
    logic [7:0]  fault_count_nxt;
    logic        fault_entry;

`ifdef SAFETY_RAMP_EN
    logic [15:0] ramp_cnt, ramp_cnt_nxt;
    logic [15:0] ramp_target;

    // Clamp to zero current when the remaining distance fits in one step, so the ramp never overshoots.
    always_comb begin
        ramp_target = dac_out;
        if (dac_out > DAC_ZERO)
            ramp_target = ((dac_out - DAC_ZERO) <= RAMP_STEP) ? DAC_ZERO : (dac_out - RAMP_STEP);
        else if (dac_out < DAC_ZERO)
            ramp_target = ((DAC_ZERO - dac_out) <= RAMP_STEP) ? DAC_ZERO : (dac_out + RAMP_STEP);
    end
`else
    logic [31:0] unused_ramp_params;
    assign unused_ramp_params = {RAMP_STEP, RAMP_DIV};
`endif

    always_comb begin
        state_nxt      = state;
        dac_nxt        = dac_out;
        settle_cnt_nxt = settle_cnt;
        fault_entry    = 1'b0;
`ifdef SAFETY_RAMP_EN
        ramp_cnt_nxt   = ramp_cnt;
`endif
        case (state)
            IDLE: begin
                dac_nxt = DAC_ZERO;
                if (enable_req && !fault_in) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                end
            end
            SETTLE: begin
                dac_nxt = DAC_ZERO;
                if (fault_in)
                    fault_entry = 1'b1;
                else if (!enable_req)
                    state_nxt = IDLE;
                else if (({1'b0, settle_cnt} + 17'd1) >= {1'b0, SETTLE_CYCLES}) begin
                    state_nxt = RUN;
                    dac_nxt   = dac_cmd_in;
                end else
                    settle_cnt_nxt = settle_cnt + 16'd1;
            end
            RUN: begin
                if (fault_in)
                    fault_entry = 1'b1;
                else if (!enable_req) begin
                    state_nxt = IDLE;
                    dac_nxt   = DAC_ZERO;
                end else
                    dac_nxt = dac_cmd_in;
            end
`ifdef SAFETY_RAMP_EN
            RAMP: begin
                if (dac_out == DAC_ZERO)
                    state_nxt = FAULT;
                else if (ramp_cnt >= (RAMP_DIV - 16'd1)) begin
                    ramp_cnt_nxt = '0;
                    dac_nxt      = ramp_target;
                end else
                    ramp_cnt_nxt = ramp_cnt + 16'd1;
            end
`endif
            FAULT: begin
                dac_nxt = DAC_ZERO;
                if (clear_req && !fault_in)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                dac_nxt   = DAC_ZERO;
            end
        endcase

        // Fault entry holds the last command so the ramp starts from where the amplifier actually is.
        if (fault_entry) begin
`ifdef SAFETY_RAMP_EN
            state_nxt    = RAMP;
            ramp_cnt_nxt = '0;
            dac_nxt      = dac_out;
`else
            state_nxt    = FAULT;
            dac_nxt      = DAC_ZERO;
`endif
        end

        fault_count_nxt = (fault_entry && (fault_count != 8'hFF)) ? (fault_count + 8'd1) : fault_count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dac_out       <= DAC_ZERO;
            amp_enable    <= 1'b0;
            fault_latched <= 1'b0;
            fault_count   <= '0;
            settle_cnt    <= '0;
`ifdef SAFETY_RAMP_EN
            ramp_cnt      <= '0;
`endif
        end else begin
            state         <= state_nxt;
            dac_out       <= dac_nxt;
            amp_enable    <= (state_nxt == SETTLE) || (state_nxt == RUN) || (state_nxt == RAMP);
            fault_latched <= (state_nxt == RAMP) || (state_nxt == FAULT);
            fault_count   <= fault_count_nxt;
            settle_cnt    <= settle_cnt_nxt;
`ifdef SAFETY_RAMP_EN
            ramp_cnt      <= ramp_cnt_nxt;
`endif
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_safety_fault_responder.sv
// tb/tb_safety_fault_responder.sv - directed scoreboard bench for safety_fault_responder
module tb_safety_fault_responder;

    localparam logic [15:0] Z = 16'h8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fault_in = 1'b0;
    logic [15:0] dac_cmd_in = 16'h8000;
    logic        enable_req = 1'b0;
    logic        clear_req = 1'b0;
    logic [15:0] dac_out;
    logic        amp_enable;
    logic        fault_latched;
    logic [2:0]  state_out;
    logic [7:0]  fault_count;

    safety_fault_responder #(
        .SETTLE_CYCLES(16'd10),
        .RAMP_STEP    (16'h0100),
        .RAMP_DIV     (16'd4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fault_in     (fault_in),
        .dac_cmd_in   (dac_cmd_in),
        .enable_req   (enable_req),
        .clear_req    (clear_req),
        .dac_out      (dac_out),
        .amp_enable   (amp_enable),
        .fault_latched(fault_latched),
        .state_out    (state_out),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dac;
        logic        en;
        logic        lat;
        logic [2:0]  st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [15:0] v;

    task automatic bump_cnt();
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic push_exp(input string tag, input logic [15:0] d, input logic e,
                            input logic l, input logic [2:0] s);
        exp_t x;
        x.dac = d; x.en = e; x.lat = l; x.st = s; x.cnt = exp_cnt;
        sb.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic check_head();
        exp_t  x;
        string t;
        x = sb.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (dac_out === x.dac) else begin
            n_fail++; $error("FAIL %s dac_out got %h want %h", t, dac_out, x.dac);
        end
        n_assert++;
        assert (amp_enable === x.en) else begin
            n_fail++; $error("FAIL %s amp_enable got %b want %b", t, amp_enable, x.en);
        end
        n_assert++;
        assert (fault_latched === x.lat) else begin
            n_fail++; $error("FAIL %s fault_latched got %b want %b", t, fault_latched, x.lat);
        end
        n_assert++;
        assert (state_out === x.st) else begin
            n_fail++; $error("FAIL %s state_out got %0d want %0d", t, state_out, x.st);
        end
        n_assert++;
        assert (fault_count === x.cnt) else begin
            n_fail++; $error("FAIL %s fault_count got %h want %h", t, fault_count, x.cnt);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] d, input logic e,
                       input logic l, input logic [2:0] s);
        push_exp(tag, d, e, l, s);
        @(posedge clk);
        #1;
        check_head();
    endtask

    task automatic now_chk(input string tag, input logic [15:0] d, input logic e,
                           input logic l, input logic [2:0] s);
        push_exp(tag, d, e, l, s);
        check_head();
    endtask

    task automatic settle_to_run(input logic [15:0] cmd);
        dac_cmd_in = cmd;
        enable_req = 1'b1;
        for (int i = 0; i < 10; i++) cyc("settle", Z, 1'b1, 1'b0, 3'd1);
        cyc("run_entry", cmd, 1'b1, 1'b0, 3'd2);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 now_chk("reset_async_initial", Z, 1'b0, 1'b0, 3'd0);
        @(posedge clk); #1;
        cyc("reset_hold", Z, 1'b0, 1'b0, 3'd0);
        cyc("reset_hold", Z, 1'b0, 1'b0, 3'd0);
        reset = 1'b1;

        enable_req = 1'b1; fault_in = 1'b1;
        cyc("idle_fault_blocks_enable", Z, 1'b0, 1'b0, 3'd0);
        fault_in = 1'b0;
        settle_to_run(16'h9000);
        dac_cmd_in = 16'hA000;
        cyc("run_follow", 16'hA000, 1'b1, 1'b0, 3'd2);
        dac_cmd_in = 16'h9000;
        cyc("run_follow", 16'h9000, 1'b1, 1'b0, 3'd2);

        fault_in = 1'b1; bump_cnt();
`ifdef SAFETY_RAMP_EN
        cyc("ramp_entry", 16'h9000, 1'b1, 1'b1, 3'd3);
        fault_in = 1'b0;
        v = 16'h9000;
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 3; k++) cyc("ramp_hold", v, 1'b1, 1'b1, 3'd3);
            v = v - 16'h0100;
            cyc("ramp_step", v, 1'b1, 1'b1, 3'd3);
        end
        cyc("ramp_to_fault", Z, 1'b0, 1'b1, 3'd4);
`else
        cyc("fault_direct", Z, 1'b0, 1'b1, 3'd4);
        fault_in = 1'b0;
`endif

        fault_in = 1'b1; clear_req = 1'b1;
        cyc("clear_blocked_by_fault", Z, 1'b0, 1'b1, 3'd4);
        fault_in = 1'b0;
        cyc("clear_to_idle", Z, 1'b0, 1'b0, 3'd0);
        clear_req = 1'b0;
        cyc("reenable_via_settle", Z, 1'b1, 1'b0, 3'd1);
        enable_req = 1'b0;
        cyc("settle_abort", Z, 1'b0, 1'b0, 3'd0);

        settle_to_run(16'h7F80);
        enable_req = 1'b0;
        cyc("run_disable", Z, 1'b0, 1'b0, 3'd0);
        settle_to_run(16'h7F80);

        enable_req = 1'b0; fault_in = 1'b1; bump_cnt();
`ifdef SAFETY_RAMP_EN
        cyc("fault_beats_disable", 16'h7F80, 1'b1, 1'b1, 3'd3);
        fault_in = 1'b0;
        for (int k = 0; k < 3; k++) cyc("ramp_below_hold", 16'h7F80, 1'b1, 1'b1, 3'd3);
        cyc("ramp_below_clamp", Z, 1'b1, 1'b1, 3'd3);
        cyc("ramp_below_fault", Z, 1'b0, 1'b1, 3'd4);
`else
        cyc("fault_beats_disable", Z, 1'b0, 1'b1, 3'd4);
        fault_in = 1'b0;
`endif
        clear_req = 1'b1;
        cyc("clear_idle", Z, 1'b0, 1'b0, 3'd0);
        clear_req = 1'b0;

        settle_to_run(16'h9000);
        fault_in = 1'b1; bump_cnt();
`ifdef SAFETY_RAMP_EN
        cyc("ramp_entry2", 16'h9000, 1'b1, 1'b1, 3'd3);
        fault_in = 1'b0;
        cyc("ramp_hold2", 16'h9000, 1'b1, 1'b1, 3'd3);
        cyc("ramp_hold2", 16'h9000, 1'b1, 1'b1, 3'd3);
`else
        cyc("fault_direct2", Z, 1'b0, 1'b1, 3'd4);
        fault_in = 1'b0;
`endif
        #2 reset = 1'b0;
        exp_cnt = 8'd0;
        #1 now_chk("reset_async_midflight", Z, 1'b0, 1'b0, 3'd0);
        cyc("reset_held", Z, 1'b0, 1'b0, 3'd0);
        reset = 1'b1; enable_req = 1'b0;

        for (int i = 0; i < 300; i++) begin
            enable_req = 1'b1;
            cyc("sat_settle", Z, 1'b1, 1'b0, 3'd1);
            fault_in = 1'b1; bump_cnt();
`ifdef SAFETY_RAMP_EN
            cyc("sat_ramp_from_settle", Z, 1'b1, 1'b1, 3'd3);
            fault_in = 1'b0;
`endif
            cyc("sat_fault", Z, 1'b0, 1'b1, 3'd4);
            fault_in = 1'b0; enable_req = 1'b0; clear_req = 1'b1;
            cyc("sat_clear", Z, 1'b0, 1'b0, 3'd0);
            clear_req = 1'b0;
        end
        n_assert++;
        assert (fault_count === 8'hFF) else begin
            n_fail++; $error("FAIL sat_final fault_count got %h want ff", fault_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
